// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and encodings for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int SB_REG_COUNT      = 32;
    localparam int SB_REG_ADDR_WIDTH = $clog2(SB_REG_COUNT);

    // Where an operand is sourced from at issue.
    typedef enum logic {
        FWD_SRC_REGFILE = 1'b0,
        FWD_SRC_BYPASS  = 1'b1
    } fwd_src_e;

endpackage

// File: rtl/scoreboard_table.sv
// Per-register pending / fwd_ready bit array.
// Update order within a cycle: ready sets, then writeback clear, then issue set.
// r0 is forced clear so it can never look in flight.
module scoreboard_table #(
    parameter int REG_COUNT      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                set_en,
    input  logic [REG_ADDR_WIDTH-1:0]           set_idx,
    input  logic                                clr_en,
    input  logic [REG_ADDR_WIDTH-1:0]           clr_idx,
    input  logic [1:0]                          rdy_en,
    input  logic [1:0][REG_ADDR_WIDTH-1:0]      rdy_idx,
    input  logic [1:0][REG_ADDR_WIDTH-1:0]      rd_idx,
    output logic [1:0]                          rd_pending,
    output logic [1:0]                          rd_ready,
    output logic [REG_COUNT-1:0]                pending_vec
);

    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic [REG_COUNT-1:0] fwd_ready_q, fwd_ready_d;
    logic [REG_COUNT-1:0] set_oh, clr_oh, rdy_oh;

    // Decode the write ports to one-hot masks and merge them in priority order.
    always_comb begin
        set_oh = '0;
        clr_oh = '0;
        rdy_oh = '0;
        if (set_en) set_oh[set_idx] = 1'b1;
        if (clr_en) clr_oh[clr_idx] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rdy_en[k]) rdy_oh[rdy_idx[k]] = 1'b1;
        end
        // Ready only marks registers that are actually in flight, so
        // fwd_ready stays a subset of pending.
        fwd_ready_d    = ((fwd_ready_q | (rdy_oh & pending_q)) & ~clr_oh) & ~set_oh;
        pending_d      = (pending_q & ~clr_oh) | set_oh;
        pending_d[0]   = 1'b0;
        fwd_ready_d[0] = 1'b0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            fwd_ready_q <= '0;
        end else begin
            pending_q   <= pending_d;
            fwd_ready_q <= fwd_ready_d;
        end
    end

    // Two source read ports plus the full pending view for the WAW check.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rd_pending[k] = pending_q[rd_idx[k]];
            rd_ready[k]   = fwd_ready_q[rd_idx[k]];
        end
        pending_vec = pending_q;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard unit: RAW/WAW stall generation, operand forward selects
// and a one-entry execute tracker that marks ALU results forwardable.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_COUNT      = SB_REG_COUNT,
    parameter int REG_ADDR_WIDTH = SB_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
    input  logic                      dec_uses_rs1,
    input  logic                      dec_uses_rs2,
    input  logic                      dec_writes_rd,
    input  logic                      dec_is_load,
    input  logic                      ext_stall,
    input  logic                      flush,
    input  logic                      mem_ld_done,
    input  logic [REG_ADDR_WIDTH-1:0] mem_ld_rd,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      stall,
    output logic                      issue,
    output logic                      fwd_rs1,
    output logic                      fwd_rs2
);

    logic                             ex_valid_q, ex_valid_d;
    logic [REG_ADDR_WIDTH-1:0]        ex_rd_q, ex_rd_d;
    logic                             ex_is_load_q, ex_is_load_d;

    logic [1:0][REG_ADDR_WIDTH-1:0]   src_idx;
    logic [1:0]                       src_uses, src_pend, src_rdy, src_live, src_hz;
    fwd_src_e                         src_sel [2];
    logic [REG_COUNT-1:0]             pending_vec;
    logic                             waw_hz, set_en, alu_done;

    scoreboard_table #(
        .REG_COUNT      (REG_COUNT),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .set_en      (set_en),
        .set_idx     (dec_rd),
        .clr_en      (wb_valid),
        .clr_idx     (wb_rd),
        .rdy_en      ({mem_ld_done, alu_done}),
        .rdy_idx     ({mem_ld_rd, ex_rd_q}),
        .rd_idx      (src_idx),
        .rd_pending  (src_pend),
        .rd_ready    (src_rdy),
        .pending_vec (pending_vec)
    );

    // Source and WAW hazard equations; a same-cycle writeback counts as resolved
    // because the register file is write-through.
    always_comb begin
        src_idx  = {dec_rs2, dec_rs1};
        src_uses = {dec_uses_rs2, dec_uses_rs1};
        for (int k = 0; k < 2; k++) begin
            src_live[k] = src_uses[k] && (src_idx[k] != '0) && src_pend[k]
                          && !(wb_valid && (wb_rd == src_idx[k]));
            src_hz[k]   = src_live[k] && !src_rdy[k];
            src_sel[k]  = (src_live[k] && src_rdy[k]) ? FWD_SRC_BYPASS : FWD_SRC_REGFILE;
        end
        waw_hz   = dec_writes_rd && (dec_rd != '0) && pending_vec[dec_rd]
                   && !(wb_valid && (wb_rd == dec_rd));
        stall    = dec_valid && !flush && ((|src_hz) || waw_hz);
        issue    = dec_valid && !flush && !stall && !ext_stall;
        fwd_rs1  = (src_sel[0] == FWD_SRC_BYPASS);
        fwd_rs2  = (src_sel[1] == FWD_SRC_BYPASS);
        set_en   = issue && dec_writes_rd && (dec_rd != '0);
        // ALU results become forwardable the cycle after issue unless frozen.
        alu_done = ex_valid_q && !ex_is_load_q && !ext_stall;
    end

    // Execute tracker next state: load on issue, hold under ext_stall, else drain.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_is_load_d = ex_is_load_q;
        if (issue) begin
            ex_valid_d   = set_en;
            ex_rd_d      = dec_rd;
            ex_is_load_d = dec_is_load;
        end else if (!ext_stall) begin
            ex_valid_d   = 1'b0;
        end
    end

    // Execute tracker register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic       dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0, dec_writes_rd = 1'b0, dec_is_load = 1'b0;
    logic       ext_stall = 1'b0, flush = 1'b0;
    logic       mem_ld_done = 1'b0;
    logic [4:0] mem_ld_rd = '0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_rd = '0;
    logic       stall, issue, fwd_rs1, fwd_rs2;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_writes_rd(dec_writes_rd), .dec_is_load(dec_is_load),
        .ext_stall(ext_stall), .flush(flush),
        .mem_ld_done(mem_ld_done), .mem_ld_rd(mem_ld_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .issue(issue), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend [32];
    bit m_rdy  [32];
    int m_alu_rd = -1;   // register whose ALU result becomes forwardable next unfrozen edge

    function automatic bit m_wb_hits(input int r);
        return wb_valid && (int'(wb_rd) == r);
    endfunction

    function automatic bit m_hz(input bit u, input int s);
        return u && s != 0 && m_pend[s] && !m_rdy[s] && !m_wb_hits(s);
    endfunction

    function automatic bit m_fwd(input bit u, input int s);
        return u && s != 0 && m_pend[s] && m_rdy[s] && !m_wb_hits(s);
    endfunction

    function automatic bit m_stall();
        bit waw;
        waw = dec_writes_rd && dec_rd != 0 && m_pend[dec_rd] && !m_wb_hits(int'(dec_rd));
        return dec_valid && !flush &&
               (m_hz(dec_uses_rs1, int'(dec_rs1)) || m_hz(dec_uses_rs2, int'(dec_rs2)) || waw);
    endfunction

    function automatic bit m_issue();
        return dec_valid && !flush && !m_stall() && !ext_stall;
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic m_update();
        bit np [32];
        bit nr [32];
        bit iss;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_rdy[r] = 0; end
            m_alu_rd = -1;
            return;
        end
        iss = m_issue();
        np = m_pend;
        nr = m_rdy;
        if (m_alu_rd > 0 && !ext_stall && m_pend[m_alu_rd]) nr[m_alu_rd] = 1;
        if (mem_ld_done && mem_ld_rd != 0 && m_pend[mem_ld_rd]) nr[mem_ld_rd] = 1;
        if (wb_valid) begin np[wb_rd] = 0; nr[wb_rd] = 0; end
        if (iss && dec_writes_rd && dec_rd != 0) begin np[dec_rd] = 1; nr[dec_rd] = 0; end
        np[0] = 0; nr[0] = 0;
        m_pend = np;
        m_rdy  = nr;
        if (iss) m_alu_rd = (dec_writes_rd && dec_rd != 0 && !dec_is_load) ? int'(dec_rd) : -1;
        else if (!ext_stall) m_alu_rd = -1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic edge_step();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0; dec_is_load = 0;
        ext_stall = 0; flush = 0; mem_ld_done = 0; mem_ld_rd = 0; wb_valid = 0; wb_rd = 0;
    endtask

    // ALU op: rd <- rs1 op rs2
    task automatic dec_alu(input int rd, input int rs1, input int rs2);
        dec_valid = 1; dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
        dec_uses_rs1 = 1; dec_uses_rs2 = 1; dec_writes_rd = 1; dec_is_load = 0;
    endtask

    // Load: rd <- mem[rs1 + imm]
    task automatic dec_ld(input int rd, input int rs1);
        dec_valid = 1; dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 0;
        dec_uses_rs1 = 1; dec_uses_rs2 = 0; dec_writes_rd = 1; dec_is_load = 1;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1;
        edge_step();
        reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pulse_reset();
        #1;
        n_tests++;
        if ({stall, issue, fwd_rs1, fwd_rs2} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs got %b want 0000", {stall, issue, fwd_rs1, fwd_rs2});
        end
        n_tests++;
        if (dut.u_table.pending_vec !== 32'h0) begin
            n_fail++; $display("FAIL reset_pending got %h want 0", dut.u_table.pending_vec);
        end
    endtask

    task automatic test_nops();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            dec_alu(0, 0, 0);
            #1;
            n_tests++;
            if ({stall, issue, fwd_rs1, fwd_rs2} !== 4'b0100) begin
                n_fail++; $display("FAIL nop_cycle%0d got %b want 0100", i, {stall, issue, fwd_rs1, fwd_rs2});
            end
            edge_step();
        end
        idle(); #1;
        n_tests++;
        if (dut.u_table.pending_vec !== 32'h0) begin
            n_fail++; $display("FAIL nop_pending got %h want 0", dut.u_table.pending_vec);
        end
    endtask

    task automatic test_alu_raw();
        pulse_reset();
        dec_alu(2, 1, 1); #1;
        n_tests++;
        if (issue !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue got %b want 1", issue); end
        edge_step();
        dec_alu(3, 2, 2); #1;
        n_tests++;
        if ({stall, issue} !== 2'b10) begin
            n_fail++; $display("FAIL raw_stall got %b want 10", {stall, issue});
        end
        edge_step(); #1;
        n_tests++;
        if ({stall, issue, fwd_rs1, fwd_rs2} !== 4'b0111) begin
            n_fail++; $display("FAIL raw_fwd got %b want 0111", {stall, issue, fwd_rs1, fwd_rs2});
        end
        edge_step();
        idle();
    endtask

    task automatic test_load_use();
        pulse_reset();
        dec_ld(4, 1); #1;
        n_tests++;
        if (issue !== 1'b1) begin n_fail++; $display("FAIL ld_issue got %b want 1", issue); end
        edge_step();
        dec_alu(5, 4, 4);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({stall, issue} !== 2'b10) begin
                n_fail++; $display("FAIL ld_use_wait%0d got %b want 10", i, {stall, issue});
            end
            edge_step();
        end
        mem_ld_done = 1; mem_ld_rd = 4; #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_done_cycle stall got %b want 1", stall); end
        edge_step();
        mem_ld_done = 0; #1;
        n_tests++;
        if ({stall, issue, fwd_rs1, fwd_rs2} !== 4'b0111) begin
            n_fail++; $display("FAIL ld_use_fwd got %b want 0111", {stall, issue, fwd_rs1, fwd_rs2});
        end
        edge_step();
        idle();
    endtask

    task automatic test_waw_wb();
        pulse_reset();
        dec_alu(6, 0, 0);
        edge_step();
        dec_alu(6, 0, 0); wb_valid = 1; wb_rd = 6; #1;
        n_tests++;
        if ({stall, issue} !== 2'b01) begin
            n_fail++; $display("FAIL waw_wb got %b want 01", {stall, issue});
        end
        edge_step();
        idle(); #1;
        n_tests++;
        if (dut.u_table.pending_vec[6] !== 1'b1) begin
            n_fail++; $display("FAIL waw_pending6 got %b want 1", dut.u_table.pending_vec[6]);
        end
    endtask

    task automatic test_ext_stall();
        pulse_reset();
        dec_alu(2, 1, 1);
        edge_step();
        dec_alu(3, 2, 2); ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({stall, issue} !== 2'b10) begin
                n_fail++; $display("FAIL ext_hold%0d got %b want 10", i, {stall, issue});
            end
            edge_step();
        end
        ext_stall = 0; #1;
        n_tests++;
        if ({stall, issue} !== 2'b10) begin
            n_fail++; $display("FAIL ext_release got %b want 10", {stall, issue});
        end
        edge_step(); #1;
        n_tests++;
        if ({stall, issue, fwd_rs1} !== 3'b011) begin
            n_fail++; $display("FAIL ext_after got %b want 011", {stall, issue, fwd_rs1});
        end
        edge_step();
        idle();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        dec_alu(2, 1, 1);
        edge_step();
        dec_ld(4, 1);
        edge_step();
        idle(); #1;
        n_tests++;
        if (dut.u_table.pending_vec !== 32'h14) begin
            n_fail++; $display("FAIL mid_pending_before got %h want 00000014", dut.u_table.pending_vec);
        end
        reset = 1;
        edge_step();
        reset = 0;
        dec_alu(3, 2, 2); #1;
        n_tests++;
        if (dut.u_table.pending_vec !== 32'h0) begin
            n_fail++; $display("FAIL mid_pending_after got %h want 0", dut.u_table.pending_vec);
        end
        n_tests++;
        if ({stall, issue} !== 2'b01) begin
            n_fail++; $display("FAIL mid_issue got %b want 01", {stall, issue});
        end
        edge_step();
        idle();
    endtask

    task automatic test_random();
        logic [3:0] exp;
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 59) == 0);
            dec_valid     = ($urandom_range(0, 9) < 8);
            dec_rs1       = 5'($urandom_range(0, 4));
            dec_rs2       = 5'($urandom_range(0, 4));
            dec_rd        = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            dec_uses_rs1  = ($urandom_range(0, 3) != 0);
            dec_uses_rs2  = ($urandom_range(0, 2) != 0);
            dec_writes_rd = ($urandom_range(0, 4) != 0);
            dec_is_load   = ($urandom_range(0, 3) == 0);
            ext_stall     = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            mem_ld_done   = ($urandom_range(0, 3) == 0);
            mem_ld_rd     = 5'($urandom_range(0, 4));
            wb_valid      = ($urandom_range(0, 2) == 0);
            wb_rd         = 5'($urandom_range(0, 4));
            #1;
            exp = {m_stall(), m_issue(), m_fwd(dec_uses_rs1, int'(dec_rs1)), m_fwd(dec_uses_rs2, int'(dec_rs2))};
            n_tests++;
            if ({stall, issue, fwd_rs1, fwd_rs2} !== exp) begin
                n_fail++; $display("FAIL rand_cycle%0d {stall,issue,fwd1,fwd2} got %b want %b",
                                   c, {stall, issue, fwd_rs1, fwd_rs2}, exp);
            end
            if (c % 16 == 0) begin
                n_tests++;
                if (dut.u_table.pending_vec !== m_pend_vec()) begin
                    n_fail++; $display("FAIL rand_pending%0d got %h want %h", c, dut.u_table.pending_vec, m_pend_vec());
                end
            end
            edge_step();
        end
        reset = 0;
        idle(); #1;
        n_tests++;
        if (dut.u_table.pending_vec !== m_pend_vec()) begin
            n_fail++; $display("FAIL rand_pending_end got %h want %h", dut.u_table.pending_vec, m_pend_vec());
        end
    endtask

    initial begin
        idle();
        reset = 1;
        edge_step();
        edge_step();
        reset = 0;
        test_reset();
        test_nops();
        test_alu_raw();
        test_load_use();
        test_waw_wb();
        test_ext_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
